// File: rtl/note_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : note_lane_scheduler
// Purpose  : Owns the scrolling note lane. Keeps a circular buffer of live
//            notes, spawns notes at the right edge, scrolls them left once per
//            frame, judges drum hits against the oldest note and retires
//            missed notes.
// Ports    : clk, rst (async, active-low)
//            vsync          - one-cycle frame tick
//            request[1:0]   - spawn pulse (bit0 do, bit1 ka, 11 -> do)
//            hit_do, hit_ka - drum hit pulses (both -> do)
//            rd_idx         - renderer slot select, 0 = oldest note
//            rd_valid/rd_type/rd_x - combinational slot read port
//            note_count     - live notes
//            judge_valid/judge_code - registered one-cycle judgement strobe
//            combo          - consecutive non-miss count, saturating at 999
//            overflow       - sticky dropped-spawn flag
// Revision : 1.0 - initial release
// ============================================================================
module note_lane_scheduler #(
    parameter int         SLOTS     = 8,
    parameter logic [9:0] X_SPAWN   = 10'd600,
    parameter logic [9:0] X_JUDGE   = 10'd100,
    parameter int         SPEED     = 4,
    parameter int         GREAT_WIN = 8,
    parameter int         GOOD_WIN  = 20,
    localparam int        IW        = $clog2(SLOTS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic [1:0]    request,
    input  logic          hit_do,
    input  logic          hit_ka,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic          rd_type,
    output logic [9:0]    rd_x,
    output logic [IW:0]   note_count,
    output logic          judge_valid,
    output logic [1:0]    judge_code,
    output logic [9:0]    combo,
    output logic          overflow
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SCROLL  = 3'd1;
    localparam logic [2:0] S_MISSCHK = 3'd2;
    localparam logic [2:0] S_JUDGE   = 3'd3;
    localparam logic [2:0] S_SPAWN   = 3'd4;

    localparam logic [1:0]  C_GREAT   = 2'd0;
    localparam logic [1:0]  C_GOOD    = 2'd1;
    localparam logic [1:0]  C_MISS    = 2'd2;
    localparam logic [9:0]  C_SPEED   = 10'(SPEED);
    localparam logic [9:0]  C_GREAT_W = 10'(GREAT_WIN);
    localparam logic [9:0]  C_GOOD_W  = 10'(GOOD_WIN);
    localparam logic [9:0]  C_MISS_X  = X_JUDGE - 10'(GOOD_WIN);
    localparam logic [IW:0] C_FULL    = (IW+1)'(SLOTS);
    localparam logic [IW-1:0] C_LAST  = IW'(SLOTS-1);
    localparam logic [9:0]  C_COMBO_MAX = 10'd999;

    logic [2:0]       state_q, state_d;
    logic [IW-1:0]    head_q, head_d, tail_q, tail_d, idx_q, idx_d;
    logic [IW:0]      count_q, count_d;
    logic [SLOTS-1:0] valid_q, valid_d, type_q, type_d;
    logic [9:0]       x_q [SLOTS];
    logic [9:0]       x_d [SLOTS];
    logic [9:0]       combo_q, combo_d;
    logic             overflow_q, overflow_d;
    logic             judge_valid_q, judge_valid_d;
    logic [1:0]       judge_code_q, judge_code_d;
    logic             pend_frame_q, pend_frame_d;
    logic             pend_spawn_q, pend_spawn_d;
    logic             spawn_type_q, spawn_type_d;
    logic             pend_hit_q, pend_hit_d;
    logic             hit_type_q, hit_type_d;

    logic [9:0]       w_head_x;
    logic             w_head_valid;
    logic [9:0]       w_dist;
    logic             w_miss_head;
    logic [IW-1:0]    w_scroll_slot;
    logic [IW-1:0]    w_rd_slot;

    assign w_head_x      = x_q[head_q];
    assign w_head_valid  = valid_q[head_q];
    assign w_dist        = (w_head_x >= X_JUDGE) ? (w_head_x - X_JUDGE) : (X_JUDGE - w_head_x);
    assign w_miss_head   = w_head_valid && (w_head_x < C_MISS_X);
    assign w_scroll_slot = head_q + idx_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            head_q        <= '0;
            tail_q        <= '0;
            idx_q         <= '0;
            count_q       <= '0;
            valid_q       <= '0;
            type_q        <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i] <= '0;
            end
            combo_q       <= '0;
            overflow_q    <= 1'b0;
            judge_valid_q <= 1'b0;
            judge_code_q  <= '0;
            pend_frame_q  <= 1'b0;
            pend_spawn_q  <= 1'b0;
            spawn_type_q  <= 1'b0;
            pend_hit_q    <= 1'b0;
            hit_type_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            idx_q         <= idx_d;
            count_q       <= count_d;
            valid_q       <= valid_d;
            type_q        <= type_d;
            x_q           <= x_d;
            combo_q       <= combo_d;
            overflow_q    <= overflow_d;
            judge_valid_q <= judge_valid_d;
            judge_code_q  <= judge_code_d;
            pend_frame_q  <= pend_frame_d;
            pend_spawn_q  <= pend_spawn_d;
            spawn_type_q  <= spawn_type_d;
            pend_hit_q    <= pend_hit_d;
            hit_type_q    <= hit_type_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pend_frame_q)      state_d = S_SCROLL;
                else if (pend_hit_q)   state_d = S_JUDGE;
                else if (pend_spawn_q) state_d = S_SPAWN;
            end
            S_SCROLL:  if (idx_q == C_LAST) state_d = S_MISSCHK;
            S_MISSCHK: if (!w_miss_head)    state_d = S_IDLE;
            S_JUDGE:   state_d = S_IDLE;
            S_SPAWN:   state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output logic
    // ------------------------------------------------------------------
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        idx_d         = idx_q;
        count_d       = count_q;
        valid_d       = valid_q;
        type_d        = type_q;
        x_d           = x_q;
        combo_d       = combo_q;
        overflow_d    = overflow_q;
        judge_valid_d = 1'b0;
        judge_code_d  = judge_code_q;
        pend_frame_d  = pend_frame_q;
        pend_spawn_d  = pend_spawn_q;
        spawn_type_d  = spawn_type_q;
        pend_hit_d    = pend_hit_q;
        hit_type_d    = hit_type_q;

        case (state_q)
            S_IDLE: begin
                if (pend_frame_q) begin
                    pend_frame_d = 1'b0;
                    idx_d        = '0;
                end else if (pend_hit_q) begin
                    pend_hit_d   = 1'b0;
                end else if (pend_spawn_q) begin
                    pend_spawn_d = 1'b0;
                end
            end
            S_SCROLL: begin
                if (valid_q[w_scroll_slot]) begin
                    x_d[w_scroll_slot] = (x_q[w_scroll_slot] >= C_SPEED) ?
                                         (x_q[w_scroll_slot] - C_SPEED) : 10'd0;
                end
                idx_d = idx_q + 1'b1;
            end
            S_MISSCHK: begin
                if (w_miss_head) begin
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + 1'b1;
                    count_d         = count_q - 1'b1;
                    judge_valid_d   = 1'b1;
                    judge_code_d    = C_MISS;
                    combo_d         = '0;
                end
            end
            S_JUDGE: begin
                // Hits outside the GOOD window (or on an empty lane) are ignored.
                if (w_head_valid && (w_dist <= C_GOOD_W)) begin
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + 1'b1;
                    count_d         = count_q - 1'b1;
                    judge_valid_d   = 1'b1;
                    if (type_q[head_q] != hit_type_q) begin
                        judge_code_d = C_MISS;
                        combo_d      = '0;
                    end else begin
                        judge_code_d = (w_dist <= C_GREAT_W) ? C_GREAT : C_GOOD;
                        combo_d      = (combo_q >= C_COMBO_MAX) ? combo_q : combo_q + 1'b1;
                    end
                end
            end
            S_SPAWN: begin
                if (count_q != C_FULL) begin
                    valid_d[tail_q] = 1'b1;
                    type_d[tail_q]  = spawn_type_q;
                    x_d[tail_q]     = X_SPAWN;
                    tail_d          = tail_q + 1'b1;
                    count_d         = count_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Input capture runs after the dispatch clear so an event arriving on
        // the same cycle its flag is consumed is kept, not lost.
        if (vsync) begin
            pend_frame_d = 1'b1;
        end
        if (request != 2'b00) begin
            if (pend_spawn_d) begin
                overflow_d = 1'b1;
            end else begin
                pend_spawn_d = 1'b1;
                spawn_type_d = (request == 2'b10);
            end
        end
        if ((hit_do || hit_ka) && !pend_hit_d) begin
            pend_hit_d = 1'b1;
            hit_type_d = hit_ka && !hit_do;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_rd_slot   = head_q + rd_idx;
    assign rd_valid    = ({1'b0, rd_idx} < count_q) && valid_q[w_rd_slot];
    assign rd_type     = type_q[w_rd_slot];
    assign rd_x        = x_q[w_rd_slot];
    assign note_count  = count_q;
    assign judge_valid = judge_valid_q;
    assign judge_code  = judge_code_q;
    assign combo       = combo_q;
    assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_note_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_note_lane_scheduler
// Purpose  : Self-checking bench for note_lane_scheduler. A directed table,
//            hand-written overflow/reset sequences and a randomized phase,
//            all compared against a note-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_lane_scheduler;

    localparam int SLOTS  = 8;
    localparam int SETTLE = 24;
    localparam int OP_SPAWN = 0;
    localparam int OP_FRAME = 1;
    localparam int OP_HIT   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = 1'b0;
    logic [1:0] request = 2'b00;
    logic       hit_do = 1'b0;
    logic       hit_ka = 1'b0;
    logic [2:0] rd_idx = 3'd0;
    logic       rd_valid;
    logic       rd_type;
    logic [9:0] rd_x;
    logic [3:0] note_count;
    logic       judge_valid;
    logic [1:0] judge_code;
    logic [9:0] combo;
    logic       overflow;

    note_lane_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .vsync       (vsync),
        .request     (request),
        .hit_do      (hit_do),
        .hit_ka      (hit_ka),
        .rd_idx      (rd_idx),
        .rd_valid    (rd_valid),
        .rd_type     (rd_type),
        .rd_x        (rd_x),
        .note_count  (note_count),
        .judge_valid (judge_valid),
        .judge_code  (judge_code),
        .combo       (combo),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Every cycle with judge_valid high is recorded as one pulse.
    int pulses[$];
    always @(negedge clk) begin
        if (judge_valid) pulses.push_back(int'(judge_code));
    end

    // Reference model: the lane as an ordered list of notes, oldest first.
    int m_type[$];
    int m_x[$];
    int m_combo = 0;
    int m_ovf   = 0;
    int exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_op(input int op, input int arg);
        int t;
        int d;
        t = (arg == 1) ? 1 : 0;
        exp_q.delete();
        case (op)
            OP_SPAWN: begin
                if (m_x.size() < SLOTS) begin
                    m_type.push_back(t);
                    m_x.push_back(600);
                end else begin
                    m_ovf = 1;
                end
            end
            OP_FRAME: begin
                foreach (m_x[i]) m_x[i] = (m_x[i] >= 4) ? m_x[i] - 4 : 0;
                while (m_x.size() > 0 && m_x[0] < 80) begin
                    void'(m_x.pop_front());
                    void'(m_type.pop_front());
                    exp_q.push_back(2);
                    m_combo = 0;
                end
            end
            default: begin
                if (m_x.size() > 0) begin
                    d = (m_x[0] >= 100) ? m_x[0] - 100 : 100 - m_x[0];
                    if (d <= 20) begin
                        if (m_type[0] != t) begin
                            exp_q.push_back(2);
                            m_combo = 0;
                        end else begin
                            exp_q.push_back((d <= 8) ? 0 : 1);
                            if (m_combo < 999) m_combo++;
                        end
                        void'(m_x.pop_front());
                        void'(m_type.pop_front());
                    end
                end
            end
        endcase
    endfunction

    task automatic check_model();
        chk("count", note_count, m_x.size());
        chk("combo", combo, m_combo);
        chk("overflow", overflow, m_ovf);
        for (int i = 0; i < SLOTS; i++) begin
            rd_idx = 3'(i);
            #1;
            chk("rd_valid", rd_valid, (i < m_x.size()) ? 1 : 0);
            if (i < m_x.size()) begin
                chk("rd_type", rd_type, m_type[i]);
                chk("rd_x", rd_x, m_x[i]);
            end
        end
        rd_idx = 3'd0;
    endtask

    task automatic do_op(input int op, input int arg);
        int p0;
        p0 = pulses.size();
        @(posedge clk); #1;
        case (op)
            OP_SPAWN: request = (arg == 1) ? 2'b10 : (arg == 2) ? 2'b11 : 2'b01;
            OP_FRAME: vsync = 1'b1;
            default: begin
                if (arg == 1) hit_ka = 1'b1;
                else if (arg == 2) begin hit_do = 1'b1; hit_ka = 1'b1; end
                else hit_do = 1'b1;
            end
        endcase
        @(posedge clk); #1;
        request = 2'b00; vsync = 1'b0; hit_do = 1'b0; hit_ka = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
        model_op(op, arg);
        chk("pulse_count", pulses.size() - p0, exp_q.size());
        for (int k = 0; k < exp_q.size() && (p0 + k) < pulses.size(); k++)
            chk("pulse_code", pulses[p0 + k], exp_q[k]);
        check_model();
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b0;
        request = 2'b00; vsync = 1'b0; hit_do = 1'b0; hit_ka = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        m_type.delete(); m_x.delete(); m_combo = 0; m_ovf = 0;
    endtask

    typedef struct {
        int op;
        int arg;
        int reps;
        int exp_count;
        int exp_combo;
        int exp_pulse;   // -1: no pulse in this row
        int exp_x0;      // -1: slot 0 not checked
        int exp_ovf;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int r;
        vec[0]  = '{OP_SPAWN, 0,   1, 1, 0, -1, 600, 0};
        vec[1]  = '{OP_FRAME, 0,   1, 1, 0, -1, 596, 0};
        vec[2]  = '{OP_FRAME, 0, 124, 1, 0, -1, 100, 0};
        vec[3]  = '{OP_HIT,   0,   1, 0, 1,  0,  -1, 0};
        vec[4]  = '{OP_SPAWN, 1,   1, 1, 1, -1, 600, 0};
        vec[5]  = '{OP_FRAME, 0, 122, 1, 1, -1, 112, 0};
        vec[6]  = '{OP_HIT,   1,   1, 0, 2,  1,  -1, 0};
        vec[7]  = '{OP_SPAWN, 0,   1, 1, 2, -1, 600, 0};
        vec[8]  = '{OP_FRAME, 0, 125, 1, 2, -1, 100, 0};
        vec[9]  = '{OP_HIT,   1,   1, 0, 0,  2,  -1, 0};
        vec[10] = '{OP_SPAWN, 2,   1, 1, 0, -1, 600, 0};
        vec[11] = '{OP_FRAME, 0, 130, 1, 0, -1,  80, 0};
        vec[12] = '{OP_FRAME, 0,   1, 0, 0,  2,  -1, 0};
        vec[13] = '{OP_SPAWN, 0,   1, 1, 0, -1, 600, 0};
        vec[14] = '{OP_FRAME, 0,  50, 1, 0, -1, 400, 0};
        vec[15] = '{OP_HIT,   0,   1, 1, 0, -1, 400, 0};
        vec[16] = '{OP_FRAME, 0,  70, 1, 0, -1, 120, 0};
        vec[17] = '{OP_HIT,   2,   1, 0, 1,  1,  -1, 0};

        // Reset state
        #3;
        chk("rst_count", note_count, 0);
        chk("rst_judge_valid", judge_valid, 0);
        chk("rst_judge_code", judge_code, 0);
        chk("rst_combo", combo, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_rd_valid", rd_valid, 0);
        reset_dut();

        // Directed table
        for (int i = 0; i < NV; i++) begin
            p0 = pulses.size();
            for (int k = 0; k < vec[i].reps; k++) do_op(vec[i].op, vec[i].arg);
            chk("tbl_count", note_count, vec[i].exp_count);
            chk("tbl_combo", combo, vec[i].exp_combo);
            chk("tbl_overflow", overflow, vec[i].exp_ovf);
            chk("tbl_npulse", pulses.size() - p0, (vec[i].exp_pulse < 0) ? 0 : 1);
            if (vec[i].exp_pulse >= 0 && pulses.size() > p0)
                chk("tbl_code", pulses[p0], vec[i].exp_pulse);
            if (vec[i].exp_x0 >= 0) begin
                rd_idx = 3'd0;
                #1;
                chk("tbl_rd_valid0", rd_valid, 1);
                chk("tbl_rd_x0", rd_x, vec[i].exp_x0);
            end
        end

        // Fill to capacity, then one more spawn is dropped
        reset_dut();
        for (int i = 0; i < 9; i++) do_op(OP_SPAWN, (i == 8) ? 1 : (i % 2));
        chk("full_count", note_count, 8);
        chk("full_overflow", overflow, 1);
        rd_idx = 3'd0;
        #1;
        chk("full_oldest_type", rd_type, 0);
        chk("full_oldest_x", rd_x, 600);
        // All eight reach the miss line together: eight back-to-back MISS pulses
        p0 = pulses.size();
        for (int i = 0; i < 131; i++) do_op(OP_FRAME, 0);
        chk("burst_miss_pulses", pulses.size() - p0, 8);
        chk("burst_count", note_count, 0);
        for (int i = 0; i < 8; i++) do_op(OP_SPAWN, int'($urandom_range(2, 0)));

        // Reset in the middle of a scroll with a hit and a spawn pending
        @(posedge clk); #1;
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        hit_do = 1'b1; request = 2'b01;
        @(posedge clk); #1;
        hit_do = 1'b0; request = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", note_count, 0);
        chk("mid_rst_combo", combo, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_judge_valid", judge_valid, 0);
        chk("mid_rst_judge_code", judge_code, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        m_type.delete(); m_x.delete(); m_combo = 0; m_ovf = 0;
        p0 = pulses.size();
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_pulses", pulses.size() - p0, 0);
        chk("post_rst_count", note_count, 0);
        do_op(OP_FRAME, 0);

        // Randomized phase against the model
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(99, 0));
            if (r < 70)      do_op(OP_FRAME, 0);
            else if (r < 78) do_op(OP_SPAWN, int'($urandom_range(2, 0)));
            else             do_op(OP_HIT, int'($urandom_range(2, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
